dmem_responder: RTL and testbench

// - Responder end of the CPU's data-memory port: accepts load/store requests from MEM stage, returns read data.
// - Models a multi-cycle data memory with valid/ready handshake; drives a busy signal feeding the hazard/stall logic.
// - Sits between the MEM stage and the backing word-addressed storage array.

---
 rtl/cpu_mem_pkg.sv | 9 +
 rtl/dmem_responder_array.sv | 26 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
//   dmem_state_t : responder FSM states
//   DMEM_DATA_W  : default data word width
//   DMEM_LAT_W   : width of the latency down-counter (covers LATENCY up to 15)
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_LAT_W  = 4;
endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port synchronous RAM backing the data-memory responder.
// There is no reset, so contents are undefined until they are written.
// A write and a read on the same edge return the old word. The responder
// never relies on that case, because a store's rdata is masked.
//   clk   : rising-edge clock
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (word at addr on the last edge)
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory port.
// It accepts one load or store per handshake and completes it LATENCY cycles
// after the accept edge, with a one-cycle rsp_valid pulse.
//   clk, rst            : clock; asynchronous active-low reset
//   req_valid/req_ready : request handshake (accept = both high at an edge)
//   req_we              : 1 = store, 0 = load
//   req_addr            : word address (the low ADDR_W bits index the storage)
//   req_wdata           : store data
//   rsp_valid           : high for exactly the completion (RESP) cycle
//   rsp_rdata           : load data during RESP, otherwise 0
//   busy                : an access is waiting out its latency (state WAIT)
//   rsp_err             : out-of-range address flag, coincident with rsp_valid
// Optional feature macro DMEM_ERR_EN. When it is defined, an access whose
// upper address bits are not all zero completes with rsp_err=1 and
// rsp_rdata=0, and a store to such an address is dropped.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              rsp_err
);
  // WAIT lasts LATENCY-1 cycles. The counter is loaded with LATENCY-2 and
  // leaves WAIT when it reaches 0.
  localparam logic [DMEM_LAT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? DMEM_LAT_W'(LATENCY - 2) : '0;

  dmem_state_t           state, state_nxt;
  logic [DMEM_LAT_W-1:0] cnt, cnt_nxt;

  logic              hold_we, hold_err;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;

  logic              accept, enter_resp, addr_err;
  logic              sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, ram_rdata;

`ifdef DMEM_ERR_EN
  assign addr_err = |req_addr[15:ADDR_W];
`else
  logic unused_hi;
  assign addr_err  = 1'b0;
  assign unused_hi = ^req_addr[15:ADDR_W];
`endif

  assign req_ready = rst && (state != WAIT);
  assign accept    = req_valid && req_ready;

  // The array access happens on the edge that enters RESP. From WAIT the
  // held request drives the array. With LATENCY==1 that edge is the accept
  // edge itself, so the live request drives the array instead.
  assign enter_resp = (state == WAIT && cnt == '0) || (accept && LATENCY == 1);
  assign sel_we     = (state == WAIT) ? hold_we    : req_we;
  assign sel_err    = (state == WAIT) ? hold_err   : addr_err;
  assign sel_addr   = (state == WAIT) ? hold_addr  : req_addr[ADDR_W-1:0];
  assign sel_wdata  = (state == WAIT) ? hold_wdata : req_wdata;

  dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (enter_resp && sel_we && !sel_err),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
          cnt_nxt   = CNT_INIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_we    <= 1'b0;
      hold_err   <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hold_we    <= req_we;
        hold_err   <= addr_err;
        hold_addr  <= req_addr[ADDR_W-1:0];
        hold_wdata <= req_wdata;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state == WAIT);
  assign rsp_rdata = (rsp_valid && !hold_we && !hold_err) ? ram_rdata : '0;
`ifdef DMEM_ERR_EN
  assign rsp_err   = rsp_valid && hold_err;
`else
  assign rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. It runs two instances side by side:
// d=0 with LATENCY=2 and d=1 with LATENCY=1.
// Expected responses come from a per-instance word memory model.
module tb_dmem_responder;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rv  [2];
  logic        rwe [2];
  logic [15:0] ra  [2];
  logic [15:0] rwd [2];
  logic        rr  [2];
  logic        vv  [2];
  logic [15:0] rd  [2];
  logic        bz  [2];
  logic        er  [2];

  int          lat [2] = '{2, 1};
  logic [15:0] mdl [2][4096];
  bit          wrn [2][4096];
  int          n_chk = 0, n_fail = 0;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(16), .ADDR_W(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_ready(rr[0]), .rsp_valid(vv[0]), .rsp_rdata(rd[0]),
    .busy(bz[0]), .rsp_err(er[0]));

  dmem_responder #(.DATA_W(16), .ADDR_W(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_ready(rr[1]), .rsp_valid(vv[1]), .rsp_rdata(rd[1]),
    .busy(bz[1]), .rsp_err(er[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated access on instance d. The task checks the full response
  // timeline against the memory model and then updates the model.
  task automatic access(input int d, input bit we, input logic [15:0] a, input logic [15:0] wd);
    bit          err, known;
    logic [15:0] exp_d;
    int          ix;
    @(negedge clk);
    rv[d] = 1'b1; rwe[d] = we; ra[d] = a; rwd[d] = wd;
    chk("ready_before_accept", 32'(rr[d]), 32'd1);
    @(posedge clk);
    #1 rv[d] = 1'b0;
    ix    = int'(a) % 4096;
    err   = ERR_EN && (a >= 16'h1000);
    known = we || err || wrn[d][ix];
    exp_d = (we || err) ? 16'h0 : mdl[d][ix];
    for (int k = 1; k <= lat[d]; k++) begin
      @(negedge clk);
      if (k < lat[d]) begin
        chk("busy_wait", 32'(bz[d]), 32'd1);
        chk("valid_early", 32'(vv[d]), 32'd0);
        chk("rdata_idle", 32'(rd[d]), 32'd0);
      end else begin
        chk("rsp_valid", 32'(vv[d]), 32'd1);
        chk("busy_resp", 32'(bz[d]), 32'd0);
        chk("rsp_err", 32'(er[d]), 32'(err));
        if (known) chk("rsp_rdata", 32'(rd[d]), 32'(exp_d));
      end
    end
    if (we && !err) begin
      mdl[d][ix] = wd;
      wrn[d][ix] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] la [4];
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; ra[d] = '0; rwd[d] = '0;
    end
    // Outputs during reset
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(rr[d]), 32'd0);
      chk("rst_valid", 32'(vv[d]), 32'd0);
      chk("rst_rdata", 32'(rd[d]), 32'd0);
      chk("rst_busy",  32'(bz[d]), 32'd0);
      chk("rst_err",   32'(er[d]), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rr[0]), 32'd1);

    // Store then load at LATENCY=2 and LATENCY=1
    access(0, 1'b1, 16'h0010, 16'hBEEF);
    access(0, 1'b0, 16'h0010, 16'h0);
    chk("beef_model", 32'(mdl[0][16]), 32'hBEEF);
    access(1, 1'b1, 16'h0010, 16'hCAFE);
    access(1, 1'b0, 16'h0010, 16'h0);

    // Reset during WAIT drops the store to address 5
    access(0, 1'b1, 16'h0005, 16'h5555);
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 16'h0005; rwd[0] = 16'h1234;
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    chk("busy_pre_rst", 32'(bz[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(rr[0]), 32'd0);
    chk("midrst_busy",  32'(bz[0]), 32'd0);
    chk("midrst_valid", 32'(vv[0]), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(vv[0]), 32'd0);
    end
    access(0, 1'b0, 16'h0005, 16'h0);

    // Address alias (or error) on an address with upper bits set
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b1, 16'h0003, 16'h3333);
      access(d, 1'b1, 16'h1003, 16'hAAAA);
      access(d, 1'b0, 16'h0003, 16'h0);
      chk("wrap_model", 32'(mdl[d][3]), ERR_EN ? 32'h3333 : 32'hAAAA);
    end

    // Back-to-back loads at LATENCY=2 with req_valid held high
    la = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
    for (int i = 0; i < 4; i++) access(0, 1'b1, la[i], 16'h7000 + 16'(i));
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk("b2b_busy",  32'(bz[0]), 32'(c % 2 == 1));
      chk("b2b_ready", 32'(rr[0]), 32'(c % 2 == 0));
      chk("b2b_valid", 32'(vv[0]), 32'(c % 2 == 0 && c > 0));
      if (c % 2 == 0 && c > 0)
        chk("b2b_rdata", 32'(rd[0]), 32'(16'h7000 + 16'(c / 2 - 1)));
      if (c < 7) begin
        rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = la[(c + 1) / 2];
      end else rv[0] = 1'b0;
    end

    // Back-to-back loads at LATENCY=1
    for (int i = 0; i < 3; i++) access(1, 1'b1, 16'(i), 16'h0B00 + 16'(i));
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("l1_ready", 32'(rr[1]), 32'd1);
      chk("l1_busy",  32'(bz[1]), 32'd0);
      chk("l1_valid", 32'(vv[1]), 32'(c >= 1));
      if (c >= 1) chk("l1_rdata", 32'(rd[1]), 32'(16'h0B00 + 16'(c - 1)));
      if (c < 3) begin
        rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 16'(c);
      end else rv[1] = 1'b0;
    end

    // Random accesses against the model
    for (int n = 0; n < 120; n++) begin
      int          d;
      logic [3:0]  hi;
      logic [15:0] a;
      d  = n % 2;
      hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      a  = {hi, 8'h0, 4'($urandom_range(0, 15))};
      access(d, 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
